// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seg_scan display multiplexer: active-low glyphs
// ({g,f,e,d,c,b,a}), slot index encodings and the latched digit snapshot.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Slot number equals the anode bit it drives.
  typedef enum logic [1:0] {
    SLOT_UNITS = 2'd0,
    SLOT_TENS  = 2'd1,
    SLOT_HUND  = 2'd2,
    SLOT_LIVES = 2'd3
  } slot_e;

  typedef struct packed {
    logic [3:0] lives;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
  } digits_t;

  // Active-low one-cold anode pattern for a slot.
  function automatic logic [3:0] slot_an(input slot_e s);
    slot_an = ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD-to-7-segment decoder (active-low); 10..15 show a dash,
// i_blank forces all segments off.
module seg_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: a default assignment on entry keeps every path driven, so no latch is inferred.
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed display driver: lives digit plus three score digits,
// frame-latched snapshot, dead time, leading-zero blanking.
// Optional lives-zero blinking is enabled by defining SEG_BLINK_EN.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] shengming,
  input  logic [3:0] fenshu2,
  input  logic [3:0] fenshu1,
  input  logic [3:0] fenshu0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 2) begin : g_bad_div
    $error("seg_scan: SCAN_DIV must be at least 2");
  end
  if (DEAD < 0 || DEAD >= SCAN_DIV) begin : g_bad_dead
    $error("seg_scan: DEAD must be in 0..SCAN_DIV-1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan: BLINK_FRAMES must be at least 1");
  end

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  slot_e            r_idx, w_idx_nxt;
  digits_t          r_snap, w_snap_nxt;
  logic             r_fresh;
  logic             w_slot_end, w_frame_end;
  logic             w_dead, w_blink_off;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_seg_nxt;
  logic [3:0]       w_an_nxt;
  logic             w_dp_nxt;

  // State register: scan position, snapshot and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= SLOT_LIVES;
      r_snap  <= '0;
      r_fresh <= 1'b1;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every register here sample pre-edge values.
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_snap  <= w_snap_nxt;
      r_fresh <= 1'b0;
      an      <= w_an_nxt;
      seg     <= w_seg_nxt;
      dp      <= w_dp_nxt;
    end
  end

  // Next-state logic; the first edge after reset also loads the snapshot.
  always_comb begin
    w_slot_end  = (r_cnt == CNT_LAST);
    w_frame_end = w_slot_end && (r_idx == SLOT_UNITS);
    w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    if (w_slot_end) begin
      w_idx_nxt = (r_idx == SLOT_UNITS) ? SLOT_LIVES : slot_e'(r_idx - 2'd1);
    end
    w_snap_nxt = r_snap;
    if (w_frame_end || r_fresh) begin
      w_snap_nxt = '{lives: shengming, hund: fenshu2, tens: fenshu1, units: fenshu0};
    end
  end

  if (DEAD == 0) begin : g_no_dead
    assign w_dead = 1'b0;
  end else begin : g_dead
    assign w_dead = (w_cnt_nxt < CNT_W'(DEAD));
  end

`ifdef SEG_BLINK_EN
  localparam int               FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [FRM_W-1:0] r_frm, w_frm_nxt;
  logic             r_phase, w_phase_nxt;

  always_comb begin
    w_frm_nxt   = r_frm;
    w_phase_nxt = r_phase;
    if (w_frame_end) begin
      if (r_frm == FRM_LAST) begin
        w_frm_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_frm_nxt = r_frm + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm   <= '0;
      r_phase <= 1'b0;
    end else begin
      r_frm   <= w_frm_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Phase and snapshot both change only at frame boundaries, so this holds for a whole frame.
  assign w_blink_off = w_phase_nxt && (w_snap_nxt.lives == 4'd0);
`else
  assign w_blink_off = 1'b0;
`endif

  // Digit mux and leading-zero blanking for the slot about to be shown.
  always_comb begin
    w_digit = w_snap_nxt.units;
    w_blank = 1'b0;
    case (w_idx_nxt)
      SLOT_LIVES: w_digit = w_snap_nxt.lives;
      SLOT_HUND: begin
        w_digit = w_snap_nxt.hund;
        w_blank = (w_snap_nxt.hund == 4'd0);
      end
      SLOT_TENS: begin
        w_digit = w_snap_nxt.tens;
        w_blank = (w_snap_nxt.hund == 4'd0) && (w_snap_nxt.tens == 4'd0);
      end
      default: w_digit = w_snap_nxt.units;
    endcase
  end

  seg_decode u_decode (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg_nxt)
  );

  // Output logic: blank slots still pull their anode low for uniform duty.
  always_comb begin
    w_an_nxt = slot_an(w_idx_nxt);
    if (w_dead || w_blink_off) begin
      w_an_nxt = 4'b1111;
    end
    w_dp_nxt = (w_idx_nxt != SLOT_LIVES);
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan with SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2.
// Define SEG_BLINK_EN on both RTL and bench to exercise the blink feature.
module tb_seg_scan;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
  localparam logic [6:0] G5 = 7'h12, G6 = 7'h02, G7 = 7'h78;
  localparam logic [6:0] GDASH = 7'h3F, GBL = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] shengming = 4'd0, fenshu2 = 4'd0, fenshu1 = 4'd0, fenshu0 = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan #(.SCAN_DIV(4), .DEAD(1), .BLINK_FRAMES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .shengming (shengming),
    .fenshu2   (fenshu2),
    .fenshu1   (fenshu1),
    .fenshu0   (fenshu0),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp_an,
                       input logic [6:0] exp_seg, input logic exp_dp, input bit an_only);
    n_checks++;
    assert (an === exp_an && (an_only || (seg === exp_seg && dp === exp_dp))) else begin
      n_fail++;
      $error("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b (an_only=%0d)",
             tag, an, seg, dp, exp_an, exp_seg, exp_dp, an_only);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit3(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
    repeat (3) begin
      tick();
      check(tag, a, s, d, 1'b0);
    end
  endtask

  task automatic slot(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
    tick();
    check({tag, "_dead"}, 4'b1111, GBL, 1'b1, 1'b1);
    lit3(tag, a, s, d);
  endtask

  task automatic frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0);
    slot({tag, "_s3"}, 4'b0111, s3, 1'b0);
    slot({tag, "_s2"}, 4'b1011, s2, 1'b1);
    slot({tag, "_s1"}, 4'b1101, s1, 1'b1);
    slot({tag, "_s0"}, 4'b1110, s0, 1'b1);
  endtask

  // First frame after reset: cycle 0 of slot 3 is consumed by the reset itself.
  task automatic first_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0);
    lit3({tag, "_s3"}, 4'b0111, s3, 1'b0);
    slot({tag, "_s2"}, 4'b1011, s2, 1'b1);
    slot({tag, "_s1"}, 4'b1101, s1, 1'b1);
    slot({tag, "_s0"}, 4'b1110, s0, 1'b1);
  endtask

  task automatic blank_frame(input string tag);
    repeat (16) begin
      tick();
      check(tag, 4'b1111, GBL, 1'b1, 1'b1);
    end
  endtask

  task automatic do_reset(input logic [3:0] l, input logic [3:0] h,
                          input logic [3:0] t, input logic [3:0] u);
    rst_n = 1'b0;
    {shengming, fenshu2, fenshu1, fenshu0} = {l, h, t, u};
    tick();
    tick();
    check("reset", 4'b1111, GBL, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Basic scan order, glyphs, dp and dead cycle.
    do_reset(4'd3, 4'd1, 4'd2, 4'd5);
    first_frame("basic", G3, G1, G2, G5);

    // Leading-zero blanking; units always shown.
    {fenshu2, fenshu1, fenshu0} = {4'd0, 4'd0, 4'd7};
    frame("lz007", G3, GBL, GBL, G7);
    {fenshu2, fenshu1, fenshu0} = {4'd0, 4'd0, 4'd0};
    frame("lz000", G3, GBL, GBL, G0);

    // Mid-frame input change is held off until the next frame boundary.
    {fenshu2, fenshu1, fenshu0} = {4'd1, 4'd2, 4'd5};
    slot("hold_s3", 4'b0111, G3, 1'b0);
    slot("hold_s2", 4'b1011, G1, 1'b1);
    fenshu0 = 4'd6;
    slot("hold_s1", 4'b1101, G2, 1'b1);
    slot("hold_s0", 4'b1110, G5, 1'b1);
    frame("upd", G3, G1, G2, G6);

    // Out-of-range digit shows a dash; inner zero with nonzero hundreds is shown.
    fenshu1 = 4'hC;
    frame("dash", G3, G1, GDASH, G6);
    fenshu1 = 4'd0;
    frame("inner0", G3, G1, G0, G6);

    // Asynchronous reset during slot 1, then restart at slot 3.
    slot("mid_s3", 4'b0111, G3, 1'b0);
    slot("mid_s2", 4'b1011, G1, 1'b1);
    tick();
    tick();
    check("mid_s1", 4'b1101, G0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 4'b1111, GBL, 1'b1, 1'b0);
    #2 rst_n = 1'b1;
    first_frame("restart", G3, G1, G0, G6);

`ifdef SEG_BLINK_EN
    // Lives 0: two scanned frames, two dark frames, then scanning again.
    do_reset(4'd0, 4'd1, 4'd2, 4'd5);
    first_frame("blinkA", G0, G1, G2, G5);
    frame("blinkB", G0, G1, G2, G5);
    blank_frame("blinkC");
    blank_frame("blinkD");
    frame("blinkE", G0, G1, G2, G5);
    frame("blinkF", G0, G1, G2, G5);
    shengming = 4'd1;
    frame("blinkG_lives1", G1, G1, G2, G5);
`else
    // Without blinking, lives 0 is a steady "0".
    do_reset(4'd0, 4'd1, 4'd2, 4'd5);
    first_frame("steadyA", G0, G1, G2, G5);
    frame("steadyB", G0, G1, G2, G5);
    frame("steadyC", G0, G1, G2, G5);
    frame("steadyD", G0, G1, G2, G5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range is 2 or more.
REQ-002 Parameter DEAD, default 500: leading cycles of each slot with all anodes off (anti-ghosting); legal range is 0 to SCAN_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 64: frames per blink half-period; legal range is 1 or more.
REQ-004 clk  input  1  system clock; the block SHALL use this single clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 shengming  input  4  lives count, binary 0..9.
REQ-007 fenshu2  input  4  score hundreds digit, BCD.
REQ-008 fenshu1  input  4  score tens digit, BCD.
REQ-009 fenshu0  input  4  score units digit, BCD.
REQ-010 an  output  4  digit enables, active-low: an[3]=lives, an[2]=hundreds, an[1]=tens, an[0]=units.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  output  1  decimal point, active-low.

Function
REQ-013 The slot counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the digit index SHALL advance 3->2->1->0->3 (slot 3 = lives, shown first).
REQ-014 When the index advances from 0 to 3 (frame boundary), all four inputs SHALL be latched together into a snapshot, so no frame mixes old and new values.
REQ-015 The display SHALL use only the snapshot; input changes SHALL appear no earlier than the next frame boundary and no later than one frame plus one slot afterward.
REQ-016 In slot cycles 0..DEAD-1, an SHALL be 4'b1111; in the remaining cycles, exactly one an bit (the current index) SHALL be 0.
REQ-017 seg and an SHALL be registered outputs, updated on the same clock edge so they change together.
REQ-018 Digits 0..9 SHALL decode to standard 7-segment glyphs; values 10..15 SHALL decode to a single dash (only g lit, seg=7'b0111111).
REQ-019 Leading-zero blanking: if fenshu2==0, slot 2 SHALL be blank (seg=7'h7F); if fenshu2==0 and fenshu1==0, slot 1 SHALL also be blank; slot 0 SHALL always be shown.
REQ-020 dp SHALL be 0 (lit) only in slot 3, separating lives from score; otherwise dp SHALL be 1.
REQ-021 A blank slot SHALL still drive its an bit low (uniform duty cycle) with seg=7'h7F.

Reset
REQ-022 While rst_n=0: an=4'b1111, seg=7'h7F, dp=1, slot counter 0, index 3, snapshot all zero, blink state cleared.
REQ-023 On release, scanning SHALL start at slot 3 with a fresh snapshot taken on the first clock edge; reset asserted mid-slot SHALL blank the outputs immediately.

Configuration
REQ-024 Macro SEG_BLINK_EN: when defined, a frame counter SHALL toggle a blink phase every BLINK_FRAMES frames; while the snapshot lives value is 0 and the phase is 1, an SHALL be forced to 4'b1111 for the whole frame.
REQ-025 When SEG_BLINK_EN is undefined, the frame counter and blink logic SHALL be absent, and lives value 0 SHALL display a steady "0".

Structure
REQ-026 A shared package SHALL hold the segment glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and the slot index encodings.
REQ-027 The BCD-to-segment decoder SHALL be a separate combinational sub-module, seg_decode, instantiated once on the muxed digit.

Verification (SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2)
REQ-028 Reset, then shengming=3, score=1,2,5 -> each 4-cycle slot has 1 blank cycle, then an=0111/seg=SEG_3/dp=0, an=1011/SEG_1, an=1101/SEG_2, an=1110/SEG_5.
REQ-029 Score 0,0,7 -> slots 2 and 1 show seg=7'h7F with their an low; slot 0 shows SEG_7; score 0,0,0 -> slot 0 shows SEG_0.
REQ-030 Change fenshu0 from 5 to 6 mid-frame -> SEG_5 is kept until the next frame boundary, then SEG_6 appears.
REQ-031 fenshu1=4'hC -> slot 1 shows 7'b0111111.
REQ-032 SEG_BLINK_EN defined, shengming=0 -> 2 frames with scanning, then 2 frames with an=1111, repeating; lives 1 -> no blanking.
REQ-033 Assert rst_n low during slot 1 -> an=1111 and seg=7F asynchronously; after release, the first lit slot is slot 3.
